// File: rtl/dmem_mmio_bridge_if.sv
// Processor data-port bus between the CPU and the data-memory/MMIO bridge.
interface dmem_mmio_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  stall;

  modport master (output req, wren, addr, wdata, input rdata, ready, stall);
  modport slave  (input req, wren, addr, wdata, output rdata, ready, stall);
endinterface

// File: rtl/dmem_mmio_bridge.sv
// Data-memory bridge: req/ready handshake onto a RAM with configurable read
// latency, plus an MMIO window holding an LED register, output FIFO and cycle counter.
module dmem_mmio_bridge #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    RAM_DEPTH    = 3840,
  parameter int                    READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE    = 12'hF00,
  parameter int                    FIFO_DEPTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_mmio_bridge_if.slave     bus,
  output logic [DATA_WIDTH-1:0] led_out,
  input  logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  localparam int RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_LED  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_FIFO = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_CNT  = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, RAM_RD, FIFO_WAIT, DONE} state_t;

  state_t                r_state, w_next_state;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_AW-1:0]     r_ram_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_lat;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_led;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_is_ram;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [RAM_AW-1:0]     w_ram_idx;
  logic [RAM_AW-1:0]     w_rd_idx;
  logic                  w_accept;
  logic                  w_ram_we, w_ram_re;
  logic                  w_rdata_ld;
  logic [DATA_WIDTH-1:0] w_rdata_nx;
  logic                  w_led_we;
  logic                  w_push, w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_cnt_clr;
  logic [1:0]            w_lat_nx;
  logic                  w_empty, w_full;

  assign w_is_ram  = (bus.addr < MMIO_BASE);
  assign w_offset  = bus.addr - MMIO_BASE;
  assign w_ram_idx = RAM_AW'(32'(bus.addr) % 32'(RAM_DEPTH));
  assign w_accept  = (r_state == IDLE) && bus.req;
  assign w_empty   = (r_count == CNT_W'(0));
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = fifo_rd && !w_empty;

  assign bus.ready  = (r_state == DONE);
  assign bus.rdata  = r_rdata;
  assign bus.stall  = bus.req && !bus.ready;
  assign led_out    = r_led;
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign fifo_dout  = w_empty ? {DATA_WIDTH{1'b0}} : r_fifo[r_rptr];

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    w_rd_idx     = r_ram_idx;
    w_rdata_ld   = 1'b0;
    w_rdata_nx   = {DATA_WIDTH{1'b0}};
    w_led_we     = 1'b0;
    w_push       = 1'b0;
    w_push_data  = r_wdata;
    w_cnt_clr    = 1'b0;
    w_lat_nx     = r_lat;
    case (r_state)
      IDLE: begin
        if (!bus.req) begin
          w_next_state = IDLE;
        end else if (w_is_ram) begin
          if (bus.wren) begin
            w_ram_we     = 1'b1;
            w_next_state = DONE;
          end else if (READ_LATENCY <= 1) begin
            w_ram_re     = 1'b1;
            w_rd_idx     = w_ram_idx;
            w_next_state = DONE;
          end else begin
            w_lat_nx     = 2'(READ_LATENCY - 2);
            w_next_state = RAM_RD;
          end
        end else begin
          w_next_state = DONE;
          case (w_offset)
            OFF_LED: begin
              if (bus.wren) begin
                w_led_we = 1'b1;
              end else begin
                w_rdata_ld = 1'b1;
                w_rdata_nx = r_led;
              end
            end
            OFF_FIFO: begin
              if (!bus.wren) begin
                w_rdata_ld = 1'b1;
                w_rdata_nx = {{(DATA_WIDTH-2){1'b0}}, w_full, w_empty};
              end else if (w_full) begin
                w_next_state = FIFO_WAIT;
              end else begin
                w_push      = 1'b1;
                w_push_data = bus.wdata;
              end
            end
            OFF_CNT: begin
              if (bus.wren) begin
                w_cnt_clr = 1'b1;
              end else begin
                w_rdata_ld = 1'b1;
                w_rdata_nx = r_cnt;
              end
            end
            default: begin
              // Unmapped offsets: writes vanish, reads return zero.
              w_rdata_ld = !bus.wren;
            end
          endcase
        end
      end
      RAM_RD: begin
        if (r_lat == 2'd0) begin
          w_ram_re     = 1'b1;
          w_next_state = DONE;
        end else begin
          w_lat_nx = r_lat - 2'd1;
        end
      end
      FIFO_WAIT: begin
        // A pop in this cycle frees the slot the pending push lands in.
        if (!w_full || fifo_rd) begin
          w_push       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_next_state = FIFO_WAIT;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // RAM storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_ram_we && !reset) begin
      r_mem[w_ram_idx] <= bus.wdata;
    end
  end

  // Request capture, latency count, read data, LED and cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ram_idx <= {RAM_AW{1'b0}};
      r_wdata   <= {DATA_WIDTH{1'b0}};
      r_lat     <= 2'd0;
      r_rdata   <= {DATA_WIDTH{1'b0}};
      r_led     <= {DATA_WIDTH{1'b0}};
      r_cnt     <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_accept) begin
        r_ram_idx <= w_ram_idx;
        r_wdata   <= bus.wdata;
      end
      r_lat <= w_lat_nx;
      if (w_ram_re) begin
        r_rdata <= r_mem[w_rd_idx];
      end else if (w_rdata_ld) begin
        r_rdata <= w_rdata_nx;
      end
      if (w_led_we) begin
        r_led <= bus.wdata;
      end
      r_cnt <= w_cnt_clr ? {DATA_WIDTH{1'b0}} : r_cnt + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= {FIFO_AW{1'b0}};
      r_rptr  <= {FIFO_AW{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_fifo[r_wptr] <= w_push_data;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: a READ_LATENCY=3 instance for the main
// vectors and a READ_LATENCY=4 instance for reset during a RAM read.
module tb_dmem_mmio_bridge;
  logic        clock = 1'b0;
  logic        reset, reset2;
  logic        fifo_rd, fifo_rd2;
  logic [31:0] led_out, fifo_dout, led_out2, fifo_dout2;
  logic        fifo_empty, fifo_full, fifo_empty2, fifo_full2;
  int          errors = 0;
  int          checks = 0;

  dmem_mmio_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
  dmem_mmio_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus2 ();

  dmem_mmio_bridge #(.READ_LATENCY(3)) dut (
    .clock(clock), .reset(reset), .bus(bus), .led_out(led_out),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  dmem_mmio_bridge #(.READ_LATENCY(4)) dut2 (
    .clock(clock), .reset(reset2), .bus(bus2), .led_out(led_out2),
    .fifo_rd(fifo_rd2), .fifo_dout(fifo_dout2), .fifo_empty(fifo_empty2), .fifo_full(fifo_full2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wren;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          exp_cyc;
    logic [31:0] exp_rd;
    logic [31:0] exp_led;
  } vec_t;

  vec_t vecs [0:12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One processor operation on dut; cyc = cycle of the ready pulse counted from accept.
  task automatic op(input logic w, input logic [11:0] a, input logic [31:0] d, input bit keep,
                    output logic [31:0] rd, output int cyc, output bit stall_ok,
                    output logic [31:0] led);
    bit done;
    bus.req = 1'b1; bus.wren = w; bus.addr = a; bus.wdata = d;
    cyc = 0; stall_ok = 1'b1; rd = 32'h0; led = 32'h0; done = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (bus.ready === 1'b1) begin
        rd = bus.rdata;
        led = led_out;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        done = 1'b1;
      end else begin
        if (bus.stall !== 1'b1) stall_ok = 1'b0;
        if (cyc >= 40) begin
          cyc = -1;
          done = 1'b1;
        end else begin
          @(posedge clock); #1;
          cyc++;
        end
      end
    end
    @(posedge clock); #1;
    if (!keep) bus.req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, led;
    int          cyc, seen;
    bit          sok;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 1, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b0, 12'h010, 32'h00000000, 3, 32'hDEADBEEF, 32'h00000000};
    vecs[2]  = '{1'b1, 12'hF00, 32'h000000A5, 1, 32'hDEADBEEF, 32'h000000A5};
    vecs[3]  = '{1'b0, 12'hF00, 32'h00000000, 1, 32'h000000A5, 32'h000000A5};
    vecs[4]  = '{1'b0, 12'hF07, 32'h00000000, 1, 32'h00000000, 32'h000000A5};
    vecs[5]  = '{1'b1, 12'hF07, 32'hFFFFFFFF, 1, 32'h00000000, 32'h000000A5};
    vecs[6]  = '{1'b0, 12'hF00, 32'h00000000, 1, 32'h000000A5, 32'h000000A5};
    vecs[7]  = '{1'b1, 12'hEFF, 32'hCAFEF00D, 1, 32'h000000A5, 32'h000000A5};
    vecs[8]  = '{1'b1, 12'h000, 32'h11111111, 1, 32'h000000A5, 32'h000000A5};
    vecs[9]  = '{1'b0, 12'hEFF, 32'h00000000, 3, 32'hCAFEF00D, 32'h000000A5};
    vecs[10] = '{1'b0, 12'h000, 32'h00000000, 3, 32'h11111111, 32'h000000A5};
    vecs[11] = '{1'b0, 12'hF01, 32'h00000000, 1, 32'h00000001, 32'h000000A5};
    vecs[12] = '{1'b0, 12'h010, 32'h00000000, 3, 32'hDEADBEEF, 32'h000000A5};

    bus.req = 1'b0; bus.wren = 1'b0; bus.addr = 12'h000; bus.wdata = 32'h0;
    bus2.req = 1'b0; bus2.wren = 1'b0; bus2.addr = 12'h000; bus2.wdata = 32'h0;
    fifo_rd = 1'b0; fifo_rd2 = 1'b0; reset = 1'b1; reset2 = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state; this is counter cycle 0.
    @(negedge clock);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_led", led_out, 32'h0);
    check("rst_empty", 32'(fifo_empty), 32'h1);
    check("rst_full", 32'(fifo_full), 32'h0);
    check("rst_dout", fifo_dout, 32'h0);
    check("rst2_led", led_out2, 32'h0);
    check("rst2_empty", 32'(fifo_empty2), 32'h1);
    check("rst2_full", 32'(fifo_full2), 32'h0);
    check("rst2_dout", fifo_dout2, 32'h0);

    // Cycle counter read in cycle 5, then clear followed immediately by a read.
    repeat (5) @(posedge clock);
    #1;
    op(1'b0, 12'hF02, 32'h0, 1'b0, rd, cyc, sok, led);
    check("cnt_read", rd, 32'd5);
    check("cnt_read_cyc", 32'(cyc), 32'd1);
    op(1'b1, 12'hF02, 32'h12345678, 1'b1, rd, cyc, sok, led);
    check("cnt_clr_cyc", 32'(cyc), 32'd1);
    op(1'b0, 12'hF02, 32'h0, 1'b0, rd, cyc, sok, led);
    check("cnt_after_clr", rd, 32'd1);

    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i <= 12; i++) begin
      op(vecs[i].wren, vecs[i].addr, vecs[i].wdata, 1'b0, rd, cyc, sok, led);
      check($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
      check($sformatf("vec%0d_stall", i), 32'(sok), 32'h1);
    end

    // FIFO: fill, stall the ninth push, release with one pop.
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 12'hF01, 32'(i), 1'b0, rd, cyc, sok, led);
      check($sformatf("push%0d_cyc", i), 32'(cyc), 32'd1);
    end
    @(negedge clock);
    check("fill_full", 32'(fifo_full), 32'h1);
    check("fill_dout", fifo_dout, 32'd1);
    @(posedge clock); #1;
    bus.req = 1'b1; bus.wren = 1'b1; bus.addr = 12'hF01; bus.wdata = 32'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("wait%0d_ready", i), 32'(bus.ready), 32'h0);
      check($sformatf("wait%0d_stall", i), 32'(bus.stall), 32'h1);
      @(posedge clock); #1;
    end
    fifo_rd = 1'b1;
    @(negedge clock);
    check("pop_same_ready", 32'(bus.ready), 32'h0);
    check("pop_same_dout", fifo_dout, 32'd1);
    @(posedge clock); #1;
    fifo_rd = 1'b0;
    @(negedge clock);
    check("push9_ready", 32'(bus.ready), 32'h1);
    check("push9_dout", fifo_dout, 32'd2);
    check("push9_full", 32'(fifo_full), 32'h1);
    @(posedge clock); #1;
    bus.req = 1'b0;
    op(1'b0, 12'hF01, 32'h0, 1'b0, rd, cyc, sok, led);
    check("fifo_status_full", rd, 32'h2);

    // Drain 2..9, then pop on empty.
    fifo_rd = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      @(negedge clock);
      check($sformatf("drain%0d", i), fifo_dout, 32'(i));
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("drained_empty", 32'(fifo_empty), 32'h1);
    @(posedge clock); #1;
    fifo_rd = 1'b0;
    @(negedge clock);
    check("pop_empty_empty", 32'(fifo_empty), 32'h1);
    check("pop_empty_dout", fifo_dout, 32'h0);
    @(posedge clock); #1;
    op(1'b1, 12'hF01, 32'h00000077, 1'b0, rd, cyc, sok, led);
    @(negedge clock);
    check("push_after_empty_dout", fifo_dout, 32'h77);
    check("push_after_empty_empty", 32'(fifo_empty), 32'h0);
    @(posedge clock); #1;

    // Back-to-back write then read with req held high.
    op(1'b1, 12'h005, 32'h0BADF00D, 1'b1, rd, cyc, sok, led);
    check("b2b_wr_cyc", 32'(cyc), 32'd1);
    op(1'b0, 12'h005, 32'h0, 1'b0, rd, cyc, sok, led);
    check("b2b_rd_cyc", 32'(cyc), 32'd3);
    check("b2b_rd_data", rd, 32'h0BADF00D);

    // dut2 (READ_LATENCY=4): write, start a read, reset it in RAM_RD.
    reset2 = 1'b0;
    bus2.req = 1'b1; bus2.wren = 1'b1; bus2.addr = 12'h020; bus2.wdata = 32'h5A5A1234;
    @(posedge clock); #1;
    @(negedge clock);
    check("d2_wr_ready", 32'(bus2.ready), 32'h1);
    @(posedge clock); #1;
    bus2.wren = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    check("d2_rd_pending", 32'(bus2.ready), 32'h0);
    reset2 = 1'b1;
    bus2.req = 1'b0;
    @(posedge clock); #1;
    reset2 = 1'b0;
    @(negedge clock);
    check("d2_abort_rdata", bus2.rdata, 32'h0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus2.ready === 1'b1) seen++;
      @(negedge clock);
    end
    check("d2_no_ready", 32'(seen), 32'h0);
    @(posedge clock); #1;
    bus2.req = 1'b1;
    cyc = 0;
    while (bus2.ready !== 1'b1 && cyc < 40) begin
      @(negedge clock);
      if (bus2.ready !== 1'b1) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    check("d2_reread_cyc", 32'(cyc), 32'd4);
    check("d2_reread_data", bus2.rdata, 32'h5A5A1234);
    @(posedge clock); #1;
    bus2.req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
Parametrised data-memory subsystem between the processor's data port and storage. It replaces the fixed single-cycle RAM hookup with a req/ready handshake and configurable RAM read latency. It also decodes a memory-mapped I/O window holding an LED register, a free-running cycle counter and an output FIFO. The processor stalls on `stall` until `ready` pulses.

Parameters:
- ADDR_WIDTH, 12, word-address width of processor port
- DATA_WIDTH, 32, data word width
- RAM_DEPTH, 3840, RAM words; must be <= MMIO_BASE
- READ_LATENCY, 1, RAM read latency in cycles after accept; legal 1..4
- MMIO_BASE, 12'hF00, first MMIO word address
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  processor memory operation valid; held stable until ready
- wren  in  1  1 = write, 0 = read; qualified by req
- addr  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  read data; valid when ready=1
- ready  out  1  one-cycle completion pulse
- stall  out  1  combinational: req & ~ready
- led_out  out  DATA_WIDTH  LED register contents
- fifo_rd  in  1  consumer pop request
- fifo_dout  out  DATA_WIDTH  FIFO head (show-ahead); 0 when empty
- fifo_empty  out  1  FIFO empty flag
- fifo_full  out  1  FIFO full flag

Behaviour:
Decode:
- addr < MMIO_BASE: RAM, indexed by addr mod RAM_DEPTH.
- addr >= MMIO_BASE: MMIO, offset = addr - MMIO_BASE.
- Offset 0, LED: read/write.
- Offset 1, FIFO: write pushes wdata; read returns {0..., fifo_full, fifo_empty} in bits [1:0].
- Offset 2, cycle counter: read returns count; any write clears it to 0.
- Other offsets: reads return 0, writes are ignored, ready still pulses.

FSM states: IDLE, RAM_RD, FIFO_WAIT, DONE.
- IDLE with req=1: latch addr, wren and wdata. This is the accept cycle (cycle 0).
- RAM write: memory updated at the accept edge; go to DONE, so ready=1 in cycle 1.
- RAM read: go to RAM_RD and count READ_LATENCY-1 further cycles, then DONE. ready=1 and rdata valid in cycle READ_LATENCY.
- MMIO read/write, FIFO not full: perform at the accept edge; DONE, ready in cycle 1.
- FIFO push with fifo_full=1: go to FIFO_WAIT and hold there until a slot frees, then push and go to DONE.
  - A fifo_rd in the same cycle as a pending push while full completes the push that cycle. Count is unchanged.
- DONE: ready=1 for exactly one cycle, then IDLE. req seen in the following IDLE is a new operation; back-to-back ops are allowed.
- req low in IDLE: stay in IDLE, ready=0.

Output timing and hold:
- rdata is registered and holds its last value outside ready pulses.
- led_out updates the cycle after accept.

FIFO:
- Circular buffer with count.
- Pop when empty is ignored.
- Push and pop in the same cycle while non-empty and non-full: count unchanged.

Cycle counter:
- DATA_WIDTH bits, +1 every cycle, wraps to 0.
- If a clear and an increment fall in the same cycle, clear wins: the next value is 0.

Reset (synchronous):
- FSM to IDLE; ready=0, rdata=0, led_out=0, counter=0.
- FIFO pointers and count to 0: fifo_empty=1, fifo_full=0, fifo_dout=0.
- RAM contents are not cleared.
- Reset mid-operation aborts the operation with no ready pulse.
  - A RAM write already committed at accept stays committed.
  - A push pending in FIFO_WAIT is dropped.

Test Plan:
- READ_LATENCY=3: write 0xDEADBEEF to addr 0x010, then read 0x010. Required: write ready in cycle 1, read ready exactly 3 cycles after accept, rdata=0xDEADBEEF, stall high for cycles 0-2 of the read.
- Write 0x0000_00A5 to 0xF00. Required: led_out=0xA5 the cycle after accept; read of 0xF00 returns 0xA5; read of 0xF07 returns 0 with ready in cycle 1.
- Push 8 values 1..8 with fifo_rd=0, then push 9. Required: fifo_full=1 after the 8th; the 9th stalls in FIFO_WAIT. Then pulse fifo_rd once: fifo_dout 1 -> 2, push 9 completes, ready pulses, full stays 1.
- Release reset, then read 0xF02 at cycle N. Required: value N. Write 0xF02 in the same cycle as an increment: the next read shows a count restarted from 0.
- Assert reset while a RAM read (READ_LATENCY=4) is in RAM_RD. Required: no ready pulse, rdata=0, FSM IDLE next cycle; a subsequent read of the same address returns the stored data.
- Back-to-back: req held high across two ops (write 0x005, then read 0x005). Required: two distinct ready pulses, the second returning the written value; fifo_rd on an empty FIFO leaves fifo_empty=1.
